// File: rtl/cpu_mem_loader_if.sv
// Host command/response streams plus the CPU external memory ports and run enable.
// The loader connects through the slave modport; the host and CPU side use master.
interface cpu_mem_loader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] addr_ext;
  logic              wen_ext;
  logic              ren_ext;
  logic [DATA_W-1:0] wdata_ext;
  logic [DATA_W-1:0] rdata_ext;
  logic [ADDR_W-1:0] addr_ext_2;
  logic              wen_ext_2;
  logic              ren_ext_2;
  logic [DATA_W-1:0] wdata_ext_2;
  logic [DATA_W-1:0] rdata_ext_2;
  logic              cpu_enable;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, rdata_ext, rdata_ext_2,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
           cpu_enable, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, rdata_ext, rdata_ext_2,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
           cpu_enable, busy
  );
endinterface

// File: rtl/cpu_mem_loader.sv
// Single-outstanding command engine driving the CPU's instruction/data memory
// ext ports and its run enable; every output is a register.
module cpu_mem_loader #(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clk,
  input  logic            arst_n,
  cpu_mem_loader_if.slave bus
);
  localparam logic [2:0] OP_WR_IMEM = 3'b000;
  localparam logic [2:0] OP_RD_IMEM = 3'b001;
  localparam logic [2:0] OP_WR_DMEM = 3'b010;
  localparam logic [2:0] OP_RD_DMEM = 3'b011;
  localparam logic [2:0] OP_RUN     = 3'b100;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RUN, S_RSP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_cmd_ready, w_cmd_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt, r_addr2, w_addr2_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt, r_wdata2, w_wdata2_nxt;
  logic              r_wen, w_wen_nxt, r_ren, w_ren_nxt;
  logic              r_wen2, w_wen2_nxt, r_ren2, w_ren2_nxt;
  logic              r_en, w_en_nxt;
  logic              r_busy, w_busy_nxt;
  logic [2:0]        r_op, w_op_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [DATA_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wen       <= 1'b0;
      r_ren       <= 1'b0;
      r_addr2     <= '0;
      r_wdata2    <= '0;
      r_wen2      <= 1'b0;
      r_ren2      <= 1'b0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wen       <= w_wen_nxt;
      r_ren       <= w_ren_nxt;
      r_addr2     <= w_addr2_nxt;
      r_wdata2    <= w_wdata2_nxt;
      r_wen2      <= w_wen2_nxt;
      r_ren2      <= w_ren2_nxt;
      r_en        <= w_en_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Latched command and shared read-latency / run down-counter; only read outside IDLE.
  always_ff @(posedge clk) begin
    r_op   <= w_op_nxt;
    r_data <= w_data_nxt;
    r_cnt  <= w_cnt_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = r_cmd_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_data_nxt  = r_rsp_data;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_addr2_nxt     = r_addr2;
    w_wdata2_nxt    = r_wdata2;
    w_wen_nxt       = 1'b0;
    w_ren_nxt       = 1'b0;
    w_wen2_nxt      = 1'b0;
    w_ren2_nxt      = 1'b0;
    w_en_nxt        = r_en;
    w_op_nxt        = r_op;
    w_data_nxt      = r_data;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid && r_cmd_ready) begin
          w_cmd_ready_nxt = 1'b0;
          w_op_nxt        = bus.cmd_op;
          w_data_nxt      = bus.cmd_data;
          case (bus.cmd_op)
            OP_WR_IMEM: begin
              w_state_nxt = S_WR;
              w_wen_nxt   = 1'b1;
              w_addr_nxt  = bus.cmd_addr;
              w_wdata_nxt = bus.cmd_data;
            end
            OP_WR_DMEM: begin
              w_state_nxt  = S_WR;
              w_wen2_nxt   = 1'b1;
              w_addr2_nxt  = bus.cmd_addr;
              w_wdata2_nxt = bus.cmd_data;
            end
            OP_RD_IMEM: begin
              w_state_nxt = S_RD;
              w_ren_nxt   = 1'b1;
              w_addr_nxt  = bus.cmd_addr;
              w_cnt_nxt   = DATA_W'(RD_LAT);
            end
            OP_RD_DMEM: begin
              w_state_nxt = S_RD;
              w_ren2_nxt  = 1'b1;
              w_addr2_nxt = bus.cmd_addr;
              w_cnt_nxt   = DATA_W'(RD_LAT);
            end
            OP_RUN: begin
              w_state_nxt = S_RUN;
              w_cnt_nxt   = bus.cmd_data;
              w_en_nxt    = (bus.cmd_data != '0);
            end
            default: begin
              w_state_nxt     = S_RSP;
              w_rsp_valid_nxt = 1'b1;
              w_rsp_err_nxt   = 1'b1;
              w_rsp_data_nxt  = '0;
            end
          endcase
        end
      end
      S_WR: begin
        w_state_nxt     = S_RSP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_data_nxt  = '0;
      end
      S_RD: begin
        if (r_cnt == '0) begin
          w_state_nxt     = S_RSP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = (r_op == OP_RD_IMEM) ? bus.rdata_ext : bus.rdata_ext_2;
        end else begin
          w_cnt_nxt  = r_cnt - 1'b1;
          w_ren_nxt  = r_ren;
          w_ren2_nxt = r_ren2;
        end
      end
      S_RUN: begin
        // Leaving on count<=1 makes enable span exactly 'count' cycles; count 0 never raises it.
        if (r_cnt <= DATA_W'(1)) begin
          w_state_nxt     = S_RSP;
          w_en_nxt        = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = r_data;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_rsp_err_nxt   = 1'b0;
          w_cmd_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_cmd_ready_nxt = 1'b1;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_en_nxt        = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.addr_ext    = r_addr;
  assign bus.wdata_ext   = r_wdata;
  assign bus.wen_ext     = r_wen;
  assign bus.ren_ext     = r_ren;
  assign bus.addr_ext_2  = r_addr2;
  assign bus.wdata_ext_2 = r_wdata2;
  assign bus.wen_ext_2   = r_wen2;
  assign bus.ren_ext_2   = r_ren2;
  assign bus.cpu_enable  = r_en;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_cpu_mem_loader.sv
// Directed bench for cpu_mem_loader with a one-cycle-latency SRAM model on each ext port.
module tb_cpu_mem_loader;
  logic clk;
  logic arst_n;
  int   n_checks;
  int   n_fail;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];

  cpu_mem_loader_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cpu_mem_loader #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.wen_ext)   imem[bus.addr_ext[7:2]]   <= bus.wdata_ext;
    if (bus.ren_ext)   bus.rdata_ext             <= imem[bus.addr_ext[7:2]];
    if (bus.wen_ext_2) dmem[bus.addr_ext_2[7:2]] <= bus.wdata_ext_2;
    if (bus.ren_ext_2) bus.rdata_ext_2           <= dmem[bus.addr_ext_2[7:2]];
  end

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_busy: cmd_ready=%b busy=%b required 1 0", bus.cmd_ready, bus.busy);
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: valid=%b err=%b data=%h required 0 0 0", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
    end
    n_checks++;
    if ({bus.wen_ext, bus.ren_ext, bus.wen_ext_2, bus.ren_ext_2, bus.cpu_enable} !== 5'b0 ||
        bus.addr_ext !== 32'h0 || bus.wdata_ext !== 32'h0 || bus.addr_ext_2 !== 32'h0 || bus.wdata_ext_2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ext: strobes=%b addr=%h wdata=%h addr2=%h wdata2=%h required all 0",
               {bus.wen_ext, bus.ren_ext, bus.wen_ext_2, bus.ren_ext_2, bus.cpu_enable},
               bus.addr_ext, bus.wdata_ext, bus.addr_ext_2, bus.wdata_ext_2);
    end
    arst_n = 1'b1;
  endtask

  task automatic test_wr_imem();
    send_cmd(3'b000, 32'h4, 32'h8C010000);
    @(negedge clk);
    n_checks++;
    if (bus.wen_ext !== 1'b1 || bus.addr_ext !== 32'h4 || bus.wdata_ext !== 32'h8C010000) begin
      n_fail++;
      $display("FAIL wr_imem_pulse: wen=%b addr=%h wdata=%h required 1 00000004 8c010000", bus.wen_ext, bus.addr_ext, bus.wdata_ext);
    end
    n_checks++;
    if (bus.wen_ext_2 !== 1'b0 || bus.ren_ext !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_imem_side: wen2=%b ren=%b rsp_valid=%b busy=%b cmd_ready=%b required 0 0 0 1 0",
               bus.wen_ext_2, bus.ren_ext, bus.rsp_valid, bus.busy, bus.cmd_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus.wen_ext !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_imem_rsp: wen=%b valid=%b data=%h err=%b required 0 1 0 0", bus.wen_ext, bus.rsp_valid, bus.rsp_data, bus.rsp_err);
    end
    n_checks++;
    if (imem[1] !== 32'h8C010000) begin
      n_fail++;
      $display("FAIL wr_imem_mem: imem[1]=%h required 8c010000", imem[1]);
    end
    take_rsp();
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_imem_done: valid=%b cmd_ready=%b busy=%b required 0 1 0", bus.rsp_valid, bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_dmem_rw();
    int ren2_cyc;
    int imem_act;
    send_cmd(3'b010, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    n_checks++;
    if (bus.wen_ext_2 !== 1'b1 || bus.addr_ext_2 !== 32'h10 || bus.wdata_ext_2 !== 32'hDEADBEEF || bus.wen_ext !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_dmem_pulse: wen2=%b addr2=%h wdata2=%h wen=%b required 1 00000010 deadbeef 0",
               bus.wen_ext_2, bus.addr_ext_2, bus.wdata_ext_2, bus.wen_ext);
    end
    @(negedge clk);
    take_rsp();
    send_cmd(3'b011, 32'h10, 32'h0);
    ren2_cyc = 0;
    imem_act = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.ren_ext_2 === 1'b1) ren2_cyc++;
      if (bus.ren_ext || bus.wen_ext || bus.rsp_valid) imem_act++;
    end
    @(negedge clk);
    n_checks++;
    if (ren2_cyc !== 2 || bus.ren_ext_2 !== 1'b0 || imem_act !== 0) begin
      n_fail++;
      $display("FAIL rd_dmem_ren: ren2 cycles=%0d ren2_after=%b early/imem activity=%0d required 2 0 0",
               ren2_cyc, bus.ren_ext_2, imem_act);
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hDEADBEEF || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_dmem_rsp: valid=%b data=%h err=%b required 1 deadbeef 0", bus.rsp_valid, bus.rsp_data, bus.rsp_err);
    end
    take_rsp();
  endtask

  task automatic test_run(input logic [31:0] count);
    int en_cyc;
    int bad;
    int k;
    send_cmd(3'b100, 32'h0, count);
    en_cyc = 0;
    bad = 0;
    k = 0;
    @(negedge clk);
    while (!bus.rsp_valid && k < 40) begin
      if (bus.cpu_enable === 1'b1) en_cyc++;
      if (bus.cmd_ready !== 1'b0 || bus.wen_ext || bus.ren_ext || bus.wen_ext_2 || bus.ren_ext_2) bad++;
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || en_cyc !== int'(count) || bad !== 0 || bus.cpu_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL run_%0d_enable: rsp_valid=%b enable cycles=%0d side activity=%0d enable_at_rsp=%b required 1 %0d 0 0",
               count, bus.rsp_valid, en_cyc, bad, bus.cpu_enable, count);
    end
    n_checks++;
    if (bus.rsp_data !== count || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL run_%0d_rsp: data=%h err=%b required %h 0", count, bus.rsp_data, bus.rsp_err, count);
    end
    take_rsp();
  endtask

  task automatic test_backpressure();
    int k;
    int unstable;
    send_cmd(3'b001, 32'h4, 32'h0);
    k = 0;
    @(negedge clk);
    while (!bus.rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b000;
    bus.cmd_addr  = 32'h3C;
    bus.cmd_data  = 32'h55AA55AA;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h8C010000 || bus.cmd_ready !== 1'b0 || bus.wen_ext !== 1'b0)
        unstable++;
      @(negedge clk);
    end
    n_checks++;
    if (unstable !== 0) begin
      n_fail++;
      $display("FAIL stall_stable: unstable cycles=%0d (valid=%b data=%h cmd_ready=%b) required 0 (1 8c010000 0)",
               unstable, bus.rsp_valid, bus.rsp_data, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b0;
    take_rsp();
    @(negedge clk);
    n_checks++;
    if (imem[15] === 32'h55AA55AA || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_no_accept: imem[15]=%h cmd_ready=%b required not 55aa55aa, 1", imem[15], bus.cmd_ready);
    end
  endtask

  task automatic test_illegal();
    int act;
    send_cmd(3'b111, 32'h20, 32'h12345678);
    act = 0;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL illegal_rsp: valid=%b err=%b data=%h required 1 1 0", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.wen_ext || bus.ren_ext || bus.wen_ext_2 || bus.ren_ext_2 || bus.cpu_enable) act++;
      @(negedge clk);
    end
    n_checks++;
    if (act !== 0) begin
      n_fail++;
      $display("FAIL illegal_quiet: active cycles=%0d required 0", act);
    end
    take_rsp();
    @(negedge clk);
    n_checks++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear: err=%b valid=%b required 0 0", bus.rsp_err, bus.rsp_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen_rsp;
    send_cmd(3'b100, 32'h0, 32'd8);
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.cpu_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre_enable: cpu_enable=%b required 1", bus.cpu_enable);
    end
    #1 arst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.cpu_enable !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_async: cpu_enable=%b cmd_ready=%b required 0 1", bus.cpu_enable, bus.cmd_ready);
    end
    @(negedge clk);
    arst_n = 1'b1;
    seen_rsp = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.cpu_enable || !bus.cmd_ready) seen_rsp++;
    end
    n_checks++;
    if (seen_rsp !== 0) begin
      n_fail++;
      $display("FAIL abort_no_rsp: bad cycles=%0d required 0", seen_rsp);
    end
    send_cmd(3'b000, 32'h8, 32'hCAFEF00D);
    @(negedge clk);
    n_checks++;
    if (bus.wen_ext !== 1'b1 || bus.addr_ext !== 32'h8 || bus.wdata_ext !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL abort_next_wr: wen=%b addr=%h wdata=%h required 1 00000008 cafef00d", bus.wen_ext, bus.addr_ext, bus.wdata_ext);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0 || imem[2] !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL abort_next_rsp: valid=%b data=%h imem[2]=%h required 1 0 cafef00d", bus.rsp_valid, bus.rsp_data, imem[2]);
    end
    take_rsp();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 64; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 3'b000;
    bus.cmd_addr    = 32'h0;
    bus.cmd_data    = 32'h0;
    bus.rsp_ready   = 1'b0;
    bus.rdata_ext   = 32'h0;
    bus.rdata_ext_2 = 32'h0;
    test_reset();
    test_wr_imem();
    test_dmem_rw();
    test_run(32'd5);
    test_run(32'd0);
    test_backpressure();
    test_illegal();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
